// File: rtl/seq_mem_rf_pkg.sv
// Shared constants and read-select encoding for the 2R2W register file.
package seq_mem_rf_pkg;

  localparam int RF_NBITS_DEFAULT = 8;
  localparam int RF_NREGS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    FWD1   = 2'd1,
    FWD0   = 2'd2,
    STORED = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/seq_mem_rf_read_port.sv
// One combinational read port: zero check, optional same-cycle forwarding, stored lookup.
// Forwarding is built only when SEQ_MEM_RF_FWD_EN is defined.
module seq_mem_rf_read_port
  import seq_mem_rf_pkg::*;
#(
  parameter int NBITS = RF_NBITS_DEFAULT,
  parameter int NREGS = RF_NREGS_DEFAULT,
  localparam int AW = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][NBITS-1:0] entries,
  input  logic [AW-1:0]               addr,
  input  logic                        write_en0,
  input  logic [AW-1:0]               write_addr0,
  input  logic [NBITS-1:0]            write_data0,
  input  logic                        write_en1,
  input  logic [AW-1:0]               write_addr1,
  input  logic [NBITS-1:0]            write_data1,
  output logic [NBITS-1:0]            data
);

`ifdef SEQ_MEM_RF_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  rd_sel_e sel_s;

  // Source selection: address 0 always wins, then port 1 forward, then port 0.
  always_comb begin
    sel_s = STORED;
    if (addr == {AW{1'b0}}) begin
      sel_s = ZERO;
    end else if (FWD_EN && write_en1 && (write_addr1 == addr)) begin
      sel_s = FWD1;
    end else if (FWD_EN && write_en0 && (write_addr0 == addr)) begin
      sel_s = FWD0;
    end else begin
      sel_s = STORED;
    end
  end

  // Data mux driven by the selected source.
  always_comb begin
    data = {NBITS{1'b0}};
    case (sel_s)
      ZERO:    data = {NBITS{1'b0}};
      FWD1:    data = write_data1;
      FWD0:    data = write_data0;
      STORED:  data = entries[addr];
      default: data = {NBITS{1'b0}};
    endcase
  end

endmodule

// File: rtl/seq_mem_param_2r2w_rf_fwz.sv
// Two-read/two-write register file with hard-zero entry 0 and per-entry dirty flags.
// Optional same-cycle write-to-read forwarding via SEQ_MEM_RF_FWD_EN.
module seq_mem_param_2r2w_rf_fwz
  import seq_mem_rf_pkg::*;
#(
  parameter int NBITS = RF_NBITS_DEFAULT,
  parameter int NREGS = RF_NREGS_DEFAULT,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    read_addr0,
  input  logic [AW-1:0]    read_addr1,
  output logic [NBITS-1:0] read_data0,
  output logic [NBITS-1:0] read_data1,
  input  logic             write_en0,
  input  logic             write_en1,
  input  logic [AW-1:0]    write_addr0,
  input  logic [AW-1:0]    write_addr1,
  input  logic [NBITS-1:0] write_data0,
  input  logic [NBITS-1:0] write_data1,
  input  logic             dirty_clear,
  output logic [NREGS-1:0] dirty
);

  logic [NREGS-1:0][NBITS-1:0] entries_r;
  logic [NREGS-1:0][NBITS-1:0] entries_nxt_s;
  logic [NREGS-1:0]            dirty_r;
  logic [NREGS-1:0]            dirty_nxt_s;

  // Next-state for storage and dirty flags; a write beats dirty_clear on its own bit.
  always_comb begin
    entries_nxt_s = entries_r;
    dirty_nxt_s   = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      if (write_en1 && (write_addr1 == AW'(i))) begin
        entries_nxt_s[i] = write_data1;
        dirty_nxt_s[i]   = 1'b1;
      end else if (write_en0 && (write_addr0 == AW'(i))) begin
        entries_nxt_s[i] = write_data0;
        dirty_nxt_s[i]   = 1'b1;
      end else begin
        entries_nxt_s[i] = entries_r[i];
        dirty_nxt_s[i]   = dirty_r[i] & ~dirty_clear;
      end
    end
    entries_nxt_s[0] = {NBITS{1'b0}};
    dirty_nxt_s[0]   = 1'b0;
  end

  // State registers, cleared immediately while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_r <= {(NREGS*NBITS){1'b0}};
      dirty_r   <= {NREGS{1'b0}};
    end else begin
      entries_r <= entries_nxt_s;
      dirty_r   <= dirty_nxt_s;
    end
  end

  assign dirty = dirty_r;

  seq_mem_rf_read_port #(.NBITS(NBITS), .NREGS(NREGS)) u_rd0 (
    .entries     (entries_r),
    .addr        (read_addr0),
    .write_en0   (write_en0),
    .write_addr0 (write_addr0),
    .write_data0 (write_data0),
    .write_en1   (write_en1),
    .write_addr1 (write_addr1),
    .write_data1 (write_data1),
    .data        (read_data0)
  );

  seq_mem_rf_read_port #(.NBITS(NBITS), .NREGS(NREGS)) u_rd1 (
    .entries     (entries_r),
    .addr        (read_addr1),
    .write_en0   (write_en0),
    .write_addr0 (write_addr0),
    .write_data0 (write_data0),
    .write_en1   (write_en1),
    .write_addr1 (write_addr1),
    .write_data1 (write_data1),
    .data        (read_data1)
  );

endmodule

// File: tb/tb_seq_mem_param_2r2w_rf_fwz.sv
// Scoreboard bench for the 2R2W register file (32 x 32), array-based reference model.
module tb_seq_mem_param_2r2w_rf_fwz;

  localparam int NB = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] read_addr0, read_addr1, write_addr0, write_addr1;
  logic [NB-1:0] read_data0, read_data1, write_data0, write_data1;
  logic          write_en0, write_en1, dirty_clear;
  logic [NR-1:0] dirty;

  seq_mem_param_2r2w_rf_fwz #(.NBITS(NB), .NREGS(NR)) dut (
    .clk(clk), .reset(reset),
    .read_addr0(read_addr0), .read_addr1(read_addr1),
    .read_data0(read_data0), .read_data1(read_data1),
    .write_en0(write_en0), .write_en1(write_en1),
    .write_addr0(write_addr0), .write_addr1(write_addr1),
    .write_data0(write_data0), .write_data1(write_data1),
    .dirty_clear(dirty_clear), .dirty(dirty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] rd0;
    logic [NB-1:0] rd1;
    logic [NR-1:0] dirty;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NB-1:0] m_mem [NR];
  logic [NR-1:0] m_dirty;
  int            n_vec = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [NB-1:0] model_read(input int a, input logic we0, input int wa0,
      input logic [NB-1:0] wd0, input logic we1, input int wa1, input logic [NB-1:0] wd1);
    if (a == 0) return '0;
`ifdef SEQ_MEM_RF_FWD_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return m_mem[a];
  endfunction

  // One cycle of stimulus: drive after the falling edge, log expectation, advance model.
  task automatic cycle(input logic rst, input logic we0, input int wa0, input logic [NB-1:0] wd0,
      input logic we1, input int wa1, input logic [NB-1:0] wd1,
      input int ra0, input int ra1, input logic dc);
    exp_t e;
    @(negedge clk); #1;
    reset = rst;
    write_en0 = we0; write_addr0 = AW'(wa0); write_data0 = wd0;
    write_en1 = we1; write_addr1 = AW'(wa1); write_data1 = wd1;
    read_addr0 = AW'(ra0); read_addr1 = AW'(ra1); dirty_clear = dc;
    if (!rst) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_dirty = '0;
    end
    e.rd0   = model_read(ra0, we0, wa0, wd0, we1, wa1, wd1);
    e.rd1   = model_read(ra1, we0, wa0, wd0, we1, wa1, wd1);
    e.dirty = m_dirty;
    exp_q.push_back(e);
    if (rst) begin
      if (dc) m_dirty = '0;
      if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_dirty[wa0] = 1'b1; end
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_dirty[wa1] = 1'b1; end
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    #3;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("read_data0", read_data0, mon_e.rd0);
      chk("read_data1", read_data1, mon_e.rd1);
      chk("dirty", NB'(dirty), NB'(mon_e.dirty));
    end
  end

  initial begin
    reset = 1'b0; write_en0 = 1'b0; write_en1 = 1'b0; dirty_clear = 1'b0;
    write_addr0 = '0; write_addr1 = '0; write_data0 = '0; write_data1 = '0;
    read_addr0 = '0; read_addr1 = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_dirty = '0;

    // reset state
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1, 7, 1'b0);
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 31, 2, 1'b0);
    // write addr 1 via port 0, then read back
    cycle(1'b1, 1'b1, 1, 32'hab, 1'b0, 0, '0, 1, 1, 1'b0);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 1, 1, 1'b0);
    // zero register
    cycle(1'b1, 1'b1, 0, 32'h01, 1'b1, 0, 32'h01, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 0, 0, 1'b0);
    // same-address collision, port 1 wins
    cycle(1'b1, 1'b1, 3, 32'h11, 1'b1, 3, 32'h22, 3, 3, 1'b0);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 3, 3, 1'b0);
    // fill 1..7, then clear with concurrent write to 5
    for (int i = 1; i <= 7; i++)
      cycle(1'b1, 1'b1, i, NB'(32'h23 + (i - 1) * 32'h22), 1'b0, 0, '0, i, 7, 1'b0);
    cycle(1'b1, 1'b1, 5, 32'h99, 1'b0, 0, '0, 6, 7, 1'b1);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 5, 4, 1'b0);
    // mid-sequence reset pulse
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 5, 3, 1'b0);
    cycle(1'b0, 1'b1, 6, 32'h55, 1'b1, 2, 32'h66, 6, 2, 1'b1);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 6, 2, 1'b0);
    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int wa0, wa1;
      wa0 = $urandom_range(0, NR - 1);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : $urandom_range(0, NR - 1);
      cycle(($urandom_range(0, 49) != 0), 1'($urandom), wa0, NB'($urandom),
            1'($urandom), wa1, NB'($urandom),
            ($urandom_range(0, 2) == 0) ? wa1 : $urandom_range(0, NR - 1),
            ($urandom_range(0, 2) == 0) ? wa0 : $urandom_range(0, NR - 1),
            ($urandom_range(0, 7) == 0));
    end
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #4;
    chk("scoreboard_drained", NB'(exp_q.size()), NB'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mem_param_2r2w_rf_fwz.md
SEQ_MEM_PARAM_2R2W_RF_FWZ -- requirements
Module: seq_mem_param_2r2w_rf_fwz

Interface
REQ-001 SHALL have parameter NBITS, default 8, data width in bits (legal 1..64).
REQ-002 SHALL have parameter NREGS, default 8, register count (power of two, 2..64); address width AW = $clog2(NREGS).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports read_addr0, read_addr1  input  AW  read port addresses.
REQ-006 SHALL have ports read_data0, read_data1  output  NBITS  read port data (combinational).
REQ-007 SHALL have ports write_en0, write_en1  input  1  write port enables.
REQ-008 SHALL have ports write_addr0, write_addr1  input  AW  write port addresses.
REQ-009 SHALL have ports write_data0, write_data1  input  NBITS  write port data.
REQ-010 SHALL have port dirty_clear  input  1  synchronous clear of all dirty bits.
REQ-011 SHALL have port dirty  output  NREGS  per-register "written since clear" flags.

Function
REQ-012 Register 0 SHALL read as all-zeros on both read ports regardless of writes; writes to address 0 SHALL be discarded and SHALL NOT set dirty[0].
REQ-013 Read ports SHALL be combinational: zero cycles latency from read_addr change to read_data.
REQ-014 Write on port k with write_en k = 1 and write_addr k != 0 SHALL update the entry at the next rising clk edge.
REQ-015 Both ports writing the same nonzero address in one cycle: port 1 data SHALL be stored (port 1 wins).
REQ-016 With forwarding enabled (REQ-024), read of nonzero address A SHALL return same-cycle write_data of a port writing A, port 1 taking priority over port 0, else stored value.
REQ-017 Forwarding SHALL never apply to address 0 (zero rule dominates).
REQ-018 dirty[i] (i != 0) SHALL set at the clk edge at which entry i is written by either port.
REQ-019 dirty_clear = 1 SHALL clear all dirty bits at the next edge; a write in the same cycle SHALL win, leaving that bit set.
REQ-020 dirty[0] SHALL be constant 0.

Reset
REQ-021 reset = 0 SHALL immediately (no clk needed) clear all entries to 0 and all dirty bits to 0.
REQ-022 While reset = 0, writes and dirty_clear SHALL be ignored; read_data0/1 SHALL read 0, except forwarded values when forwarding is enabled.
REQ-023 Deassertion SHALL take effect on the first rising clk edge with reset = 1; reset mid-sequence SHALL discard any writes not yet clocked.

Configuration
REQ-024 Macro SEQ_MEM_RF_FWD_EN: defined -> same-cycle write-to-read forwarding per REQ-016; undefined -> reads return stored value only (write visible the cycle after the edge); all other behaviour identical.

Structure
REQ-025 Package seq_mem_rf_pkg SHALL hold default NBITS/NREGS constants and the read-mux-select enum (ZERO, FWD1, FWD0, STORED).
REQ-026 One sub-module seq_mem_rf_read_port (address decode, zero check, forwarding mux) SHALL be instantiated twice; storage and dirty logic in the top module.

Verification
REQ-027 Reset then write addr 1 = 0xab via port 0, read both ports addr 1 same cycle -> 0xab with FWD_EN, 0x00 without; next cycle -> 0xab both builds.
REQ-028 Write addr 0 = 0x01 on both ports, read addr 0 -> 0x00 both ports, dirty[0] = 0 throughout.
REQ-029 Port 0 writes addr 3 = 0x11, port 1 writes addr 3 = 0x22 same cycle -> forwarded and next-cycle read = 0x22; dirty[3] = 1.
REQ-030 Fill addr 1..7 with 0x23..0xef, then dirty_clear = 1 with write addr 5 = 0x99 -> dirty = 8'b0010_0000, addr 5 reads 0x99.
REQ-031 After filling registers, pulse reset low mid-cycle between edges -> all reads 0x00 and dirty = 0 before the next clk edge.
REQ-032 NBITS=32, NREGS=32, 200 random cycles against a golden model -> read_data0/1 and dirty match every cycle.
